// File: rtl/tt_um_seq_divider_hhrb98_pkg.sv
// rtl/tt_um_seq_divider_hhrb98_pkg.sv - shared widths, FSM states and pin map for the divider
package tt_div_pkg;
    localparam int WIDTH = 4;
    localparam logic [WIDTH-1:0] DBZ_QUOT = 4'hF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int START_BIT = 0;
    localparam int BUSY_BIT  = 1;
    localparam int DONE_BIT  = 2;
    localparam int DBZ_BIT   = 3;

    localparam logic [7:0] UIO_OE_MASK = 8'h0E;
endpackage

// File: rtl/tt_um_seq_divider_hhrb98_if.sv
// rtl/tt_um_seq_divider_hhrb98_if.sv - bundle of the TinyTapeout user pins around the divider
interface tt_div_if;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uo_out;
    logic [7:0] uio_in;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    modport master (output ena, ui_in, uio_in, input uo_out, uio_out, uio_oe);
    modport slave  (input ena, ui_in, uio_in, output uo_out, uio_out, uio_oe);
endinterface

// File: rtl/tt_um_seq_divider_hhrb98_div_step.sv
// rtl/tt_um_seq_divider_hhrb98_div_step.sv - one combinational restoring-division step
module div_step
    import tt_div_pkg::*;
(
    input  logic [WIDTH:0]   p_i,
    input  logic             bit_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH:0]   p_o,
    output logic             qbit_o
);
    logic [WIDTH:0] t;
    // The partial remainder is always below B, so its top bit never carries into the shift.
    logic unused_p_msb;

    assign unused_p_msb = p_i[WIDTH];
    assign t            = {p_i[WIDTH-1:0], bit_i};

    always_comb begin
        qbit_o = (t >= {1'b0, b_i});
        p_o    = qbit_o ? (t - {1'b0, b_i}) : t;
    end
endmodule

// File: rtl/tt_um_seq_divider_hhrb98.sv
// rtl/tt_um_seq_divider_hhrb98.sv - sequential 4-bit unsigned restoring divider, TinyTapeout top
module tt_um_seq_divider_hhrb98
    import tt_div_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);
    state_t           state_q, state_d;
    logic [1:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [WIDTH:0]   p_q, p_d;
    logic [WIDTH-1:0] qw_q, qw_d, q_q, q_d, r_q, r_d;
    logic             done_q, done_d, dbz_q, dbz_d;

    logic             start;
    logic [1:0]       bit_idx;
    logic [WIDTH:0]   step_p;
    logic             step_qbit;
    logic             unused_uio_in;

    assign start         = uio_in[START_BIT];
    assign unused_uio_in = &{1'b0, uio_in[7:1]};
    // Dividend bits are consumed MSB first, one per RUN edge.
    assign bit_idx       = 2'(WIDTH - 1) - cnt_q;

    div_step u_step (
        .p_i    (p_q),
        .bit_i  (a_q[bit_idx]),
        .b_i    (b_q),
        .p_o    (step_p),
        .qbit_o (step_qbit)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        p_d     = p_q;
        qw_d    = qw_q;
        q_d     = q_q;
        r_d     = r_q;
        done_d  = done_q;
        dbz_d   = dbz_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    a_d    = ui_in[3:0];
                    b_d    = ui_in[7:4];
                    done_d = 1'b0;
                    dbz_d  = 1'b0;
                    if (ui_in[7:4] == '0) begin
                        state_d = DONE;
                        q_d     = DBZ_QUOT;
                        r_d     = ui_in[3:0];
                        dbz_d   = 1'b1;
                        done_d  = 1'b1;
                    end else begin
                        state_d = RUN;
                        cnt_d   = '0;
                        p_d     = '0;
                        qw_d    = '0;
                    end
                end
            end
            RUN: begin
                p_d   = step_p;
                qw_d  = {qw_q[WIDTH-2:0], step_qbit};
                cnt_d = cnt_q + 2'd1;
                if (cnt_q == 2'(WIDTH - 1)) begin
                    q_d     = {qw_q[WIDTH-2:0], step_qbit};
                    r_d     = step_p[WIDTH-1:0];
                    done_d  = 1'b1;
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            p_q     <= '0;
            qw_q    <= '0;
            q_q     <= '0;
            r_q     <= '0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
        end else if (ena) begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            p_q     <= p_d;
            qw_q    <= qw_d;
            q_q     <= q_d;
            r_q     <= r_d;
            done_q  <= done_d;
            dbz_q   <= dbz_d;
        end
    end

    always_comb begin
        uio_out           = 8'h00;
        uio_out[BUSY_BIT] = (state_q == RUN);
        uio_out[DONE_BIT] = done_q;
        uio_out[DBZ_BIT]  = dbz_q;
    end

    assign uo_out = {r_q, q_q};
    assign uio_oe = UIO_OE_MASK;
endmodule

// File: tb/tb_tt_um_seq_divider_hhrb98.sv
// tb/tb_tt_um_seq_divider_hhrb98.sv - scoreboard bench for the sequential divider
module tb_tt_um_seq_divider_hhrb98;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    tt_div_if bus ();

    tt_um_seq_divider_hhrb98 dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (bus.ena),
        .ui_in   (bus.ui_in),
        .uo_out  (bus.uo_out),
        .uio_in  (bus.uio_in),
        .uio_out (bus.uio_out),
        .uio_oe  (bus.uio_oe)
    );

    typedef struct {
        logic [7:0] uo;
        logic [7:0] uio;
    } exp_t;

    exp_t sbq[$];
    int   n_cmp = 0;
    int   n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: plain integer division, or the fixed divide-by-zero report.
    function automatic exp_t model(input logic [3:0] a, input logic [3:0] b);
        exp_t e;
        if (b == 4'd0) begin
            e.uo  = {a, 4'hF};
            e.uio = 8'h0C;
        end else begin
            e.uo  = {4'(a % b), 4'(a / b)};
            e.uio = 8'h04;
        end
        return e;
    endfunction

    // Monitor: a completion is done high after it was low, or done high after an accepted restart.
    logic prev_done = 1'b0;
    logic prev_go   = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            prev_done = 1'b0;
            prev_go   = 1'b0;
        end else begin
            check("uio_oe", 32'(bus.uio_oe), 32'h0E);
            if (bus.uio_out[2] && (!prev_done || prev_go)) begin
                if (sbq.size() == 0) begin
                    check("unexpected_done", 32'd1, 32'd0);
                end else begin
                    e = sbq.pop_front();
                    check("uo_out", 32'(bus.uo_out), 32'(e.uo));
                    check("uio_out", 32'(bus.uio_out), 32'(e.uio));
                end
            end
            prev_done = bus.uio_out[2];
            prev_go   = bus.uio_in[0] && bus.ena;
        end
    end

    // Entry and exit are at posedge+1. Pulses start, then counts edges until done.
    task automatic do_op(input logic [3:0] a, input logic [3:0] b, input bit extra, input bit gap,
                         input int exp_lat);
        int n;
        bus.ui_in     = {b, a};
        bus.uio_in[0] = 1'b1;
        @(posedge clk);
        sbq.push_back(model(a, b));
        #1;
        bus.uio_in[0] = 1'b0;
        bus.ui_in     = 8'($urandom);
        check("busy_after_start", 32'(bus.uio_out[1]), 32'(b != 4'd0));
        n = 0;
        while (bus.uio_out[2] == 1'b0 && n < 20) begin
            if (extra && n == 1) begin
                bus.ui_in     = 8'h21;
                bus.uio_in[0] = 1'b1;
            end else begin
                bus.uio_in[0] = 1'b0;
            end
            bus.ena = !(gap && (n == 2 || n == 3));
            @(posedge clk);
            #1;
            n++;
        end
        bus.ena       = 1'b1;
        bus.uio_in[0] = 1'b0;
        check("latency", 32'(n), 32'(exp_lat));
    endtask

    int order[256];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int j;
        int t;
        bus.ena    = 1'b1;
        bus.ui_in  = 8'h00;
        bus.uio_in = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        check("reset_uo_out", 32'(bus.uo_out), 32'h00);
        check("reset_uio_out", 32'(bus.uio_out), 32'h00);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        do_op(4'd13, 4'd3, 1'b0, 1'b0, 4);
        check("idle_after_13_3", 32'(bus.uio_out), 32'h04);
        do_op(4'd15, 4'd1, 1'b0, 1'b0, 4);
        do_op(4'd5, 4'd7, 1'b0, 1'b0, 4);
        do_op(4'd0, 4'd9, 1'b0, 1'b0, 4);
        do_op(4'd9, 4'd0, 1'b0, 1'b0, 0);
        check("dbz_uo_out", 32'(bus.uo_out), 32'h9F);
        do_op(4'd13, 4'd3, 1'b1, 1'b1, 6);
        check("ena_gap_uo_out", 32'(bus.uo_out), 32'h14);

        // Asynchronous reset in the middle of a division.
        bus.ui_in     = 8'h3D;
        bus.uio_in[0] = 1'b1;
        @(posedge clk);
        #1;
        bus.uio_in[0] = 1'b0;
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_rst_uo_out", 32'(bus.uo_out), 32'h00);
        check("async_rst_uio_out", 32'(bus.uio_out), 32'h00);
        sbq.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        do_op(4'd15, 4'd1, 1'b0, 1'b0, 4);

        // Every operand pair in shuffled order, start held high, noise on ui_in while running.
        for (int i = 0; i < 256; i++) order[i] = i;
        for (int i = 255; i > 0; i--) begin
            j        = int'($urandom_range(i, 0));
            t        = order[i];
            order[i] = order[j];
            order[j] = t;
        end
        bus.uio_in[0] = 1'b1;
        for (int i = 0; i < 256; i++) begin
            bus.ui_in = 8'(order[i]);
            @(posedge clk);
            sbq.push_back(model(bus.ui_in[3:0], bus.ui_in[7:4]));
            #1;
            if (order[i] >= 16) begin
                repeat (4) begin
                    bus.ui_in = 8'($urandom);
                    @(posedge clk);
                    #1;
                end
            end
        end
        bus.uio_in[0] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_drained", 32'(sbq.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
